// File: rtl/add_arb_pkg.sv
// Shared types and constants for the add_arb shared-adder arbiter and its
// reusable cyclic priority picker.
package add_arb_pkg;

    // Arbiter state: IDLE re-arbitrates every beat, LOCKED holds a packet owner.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Width of the end-of-transfer tag and the meaning of each bit.
    localparam int W_EOT   = 2;
    localparam int EOT_ROW = 0;
    localparam int EOT_WIN = 1;

    // A beat closes its packet when either end-of-row or end-of-window is set.
    function automatic logic eot_is_end(input logic [W_EOT-1:0] eot);
        return eot[EOT_ROW] | eot[EOT_WIN];
    endfunction

endpackage

// File: rtl/add_arb_rr_pick.sv
// Combinational cyclic priority picker: first asserted request found when
// scanning from ptr upward, wrapping at N_REQ-1 back to 0.
module rr_pick
    import add_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W_ID  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [W_ID-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [W_ID-1:0]  grant_idx,
    output logic             any
);

    logic [N_REQ-1:0] grant_s;
    logic [W_ID-1:0]  grant_idx_s;
    logic             any_s;

    // Scan the requests cyclically starting at ptr and keep the first hit.
    always_comb begin
        int             cand;
        logic [W_ID-1:0] cand_idx;
        grant_s     = '0;
        grant_idx_s = '0;
        any_s       = 1'b0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand     = (int'(ptr) + k) % N_REQ;
            cand_idx = W_ID'(cand);
            if (!any_s && req[cand_idx]) begin
                any_s             = 1'b1;
                grant_idx_s       = cand_idx;
                grant_s[cand_idx] = 1'b1;
            end else begin
                any_s = any_s;
            end
        end
    end

    assign grant     = grant_s;
    assign grant_idx = grant_idx_s;
    assign any       = any_s;

endmodule

// File: rtl/add_arb.sv
// Shared registered adder stage: round-robin arbitration between N_REQ
// valid/ready requester streams, locked for the duration of a packet, with a
// single output register that passes ready straight through.
module add_arb
    import add_arb_pkg::*;
#(
    parameter  int N_REQ  = 4,
    parameter  int W_DATA = 32,
    localparam int W_ID   = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*W_DATA-1:0]   req_a,
    input  logic [N_REQ*W_DATA-1:0]   req_b,
    input  logic [W_EOT*N_REQ-1:0]    req_eot,
    output logic                      dout_valid,
    input  logic                      dout_ready,
    output logic [W_DATA-1:0]         dout_data,
    output logic [W_ID-1:0]           dout_id,
    output logic [W_EOT-1:0]          dout_eot
);

    arb_state_t        state_r;
    logic [W_ID-1:0]   ptr_r;
    logic [W_ID-1:0]   owner_r;

    logic              dout_valid_r;
    logic [W_DATA-1:0] dout_data_r;
    logic [W_ID-1:0]   dout_id_r;
    logic [W_EOT-1:0]  dout_eot_r;

    logic              load_en_s;
    logic [N_REQ-1:0]  pick_grant_s;
    logic [W_ID-1:0]   pick_idx_s;
    logic              pick_any_s;
    logic [N_REQ-1:0]  grant_s;
    logic [W_ID-1:0]   grant_idx_s;
    logic [N_REQ-1:0]  req_ready_s;
    logic              xfer_s;
    logic [W_DATA-1:0] a_sel_s;
    logic [W_DATA-1:0] b_sel_s;
    logic [W_EOT-1:0]  eot_sel_s;
    logic [W_DATA-1:0] sum_s;
    logic              pkt_end_s;

    // Successor of a requester index, wrapping at N_REQ-1.
    function automatic logic [W_ID-1:0] next_idx(input logic [W_ID-1:0] idx);
        if (idx == W_ID'(N_REQ - 1)) begin
            return '0;
        end else begin
            return idx + W_ID'(1);
        end
    endfunction

    rr_pick #(
        .N_REQ (N_REQ),
        .W_ID  (W_ID)
    ) u_pick (
        .req       (req_valid),
        .ptr       (ptr_r),
        .grant     (pick_grant_s),
        .grant_idx (pick_idx_s),
        .any       (pick_any_s)
    );

    // The output register can take a new beat when empty or being drained.
    assign load_en_s = !dout_valid_r || dout_ready;

    // Grant follows the packet owner while locked, otherwise the picker.
    always_comb begin
        grant_s     = '0;
        grant_idx_s = pick_idx_s;
        if (state_r == LOCKED) begin
            grant_s[owner_r] = 1'b1;
            grant_idx_s      = owner_r;
        end else if (pick_any_s) begin
            grant_s = pick_grant_s;
        end else begin
            grant_s = '0;
        end
    end

    // Ready is the grant gated by output space and held low during reset.
    always_comb begin
        if (!rst && load_en_s) begin
            req_ready_s = grant_s;
        end else begin
            req_ready_s = '0;
        end
    end

    assign xfer_s    = |(req_valid & req_ready_s);
    assign a_sel_s   = req_a[int'(grant_idx_s) * W_DATA +: W_DATA];
    assign b_sel_s   = req_b[int'(grant_idx_s) * W_DATA +: W_DATA];
    assign eot_sel_s = req_eot[int'(grant_idx_s) * W_EOT +: W_EOT];
    assign sum_s     = a_sel_s + b_sel_s;
    assign pkt_end_s = eot_is_end(eot_sel_s);

    // Output register and arbitration state machine, updated together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            ptr_r        <= '0;
            owner_r      <= '0;
            dout_valid_r <= 1'b0;
            dout_data_r  <= '0;
            dout_id_r    <= '0;
            dout_eot_r   <= '0;
        end else begin
            if (load_en_s) begin
                dout_valid_r <= xfer_s;
                if (xfer_s) begin
                    dout_data_r <= sum_s;
                    dout_id_r   <= grant_idx_s;
                    dout_eot_r  <= eot_sel_s;
                end else begin
                    dout_data_r <= dout_data_r;
                    dout_id_r   <= dout_id_r;
                    dout_eot_r  <= dout_eot_r;
                end
            end else begin
                dout_valid_r <= dout_valid_r;
            end

            case (state_r)
                IDLE: begin
                    if (xfer_s && pkt_end_s) begin
                        ptr_r <= next_idx(grant_idx_s);
                    end else if (xfer_s) begin
                        state_r <= LOCKED;
                        owner_r <= grant_idx_s;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOCKED: begin
                    if (xfer_s && pkt_end_s) begin
                        state_r <= IDLE;
                        ptr_r   <= next_idx(owner_r);
                    end else begin
                        state_r <= LOCKED;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ptr_r   <= '0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_s;
    assign dout_valid = dout_valid_r;
    assign dout_data  = dout_data_r;
    assign dout_id    = dout_id_r;
    assign dout_eot   = dout_eot_r;

endmodule

// File: tb/tb_add_arb.sv
// Self-checking bench for add_arb: per-requester beat queues drive the
// handshakes, a transaction-level model predicts ready and the output beat.
module tb_add_arb;

    localparam int N = 4;
    localparam int W = 32;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [2*N-1:0]   req_eot;
    logic             dout_valid;
    logic             dout_ready;
    logic [W-1:0]     dout_data;
    logic [1:0]       dout_id;
    logic [1:0]       dout_eot;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   eot;
    } beat_t;

    beat_t      bq [N][$];
    int         out_log[$];
    int         total;
    int         bad;

    int         m_ptr;
    int         m_owner;
    bit         m_locked;
    logic       m_valid;
    logic [W-1:0] m_data;
    logic [1:0] m_id;
    logic [1:0] m_eot;

    add_arb #(.N_REQ(N), .W_DATA(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_eot    (req_eot),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_data  (dout_data),
        .dout_id    (dout_id),
        .dout_eot   (dout_eot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int r, input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] eot);
        beat_t bt;
        bt.a = a;
        bt.b = b;
        bt.eot = eot;
        bq[r].push_back(bt);
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (bq[i].size() != 0) begin
                req_valid[i]     = 1'b1;
                req_a[i*W +: W]  = bq[i][0].a;
                req_b[i*W +: W]  = bq[i][0].b;
                req_eot[2*i +: 2] = bq[i][0].eot;
            end else begin
                req_valid[i]     = 1'b0;
                req_a[i*W +: W]  = $urandom;
                req_b[i*W +: W]  = $urandom;
                req_eot[2*i +: 2] = 2'($urandom_range(0, 3));
            end
        end
    endtask

    // One clock: check ready against the model, advance, check the output.
    task automatic cycle();
        int       g;
        int       idx;
        bit       load;
        bit       xfer;
        bit       r;
        logic [N-1:0] exp_rdy;
        beat_t    bt;
        #2;
        r    = rst;
        load = !m_valid || dout_ready;
        g    = -1;
        if (m_locked) begin
            g = m_owner;
        end else begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        exp_rdy = '0;
        if (!r && load && g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        xfer = (g >= 0) && exp_rdy[g] && req_valid[g];
        bt = '0;
        if (xfer) bt = bq[g][0];
        @(posedge clk);
        #1;
        if (r) begin
            m_valid = 1'b0; m_data = '0; m_id = '0; m_eot = '0;
            m_ptr = 0; m_owner = 0; m_locked = 1'b0;
        end else if (xfer) begin
            m_valid = 1'b1;
            m_data  = bt.a + bt.b;
            m_id    = 2'(g);
            m_eot   = bt.eot;
            void'(bq[g].pop_front());
            if (bt.eot != 2'b00) begin
                m_locked = 1'b0;
                m_ptr    = (g + 1) % N;
            end else begin
                m_locked = 1'b1;
                m_owner  = g;
            end
        end else if (load) begin
            m_valid = 1'b0;
        end
        chk("dout_valid", 64'(dout_valid), 64'(m_valid));
        chk("dout_data", 64'(dout_data), 64'(m_data));
        chk("dout_id", 64'(dout_id), 64'(m_id));
        chk("dout_eot", 64'(dout_eot), 64'(m_eot));
        if (dout_valid === 1'b1) out_log.push_back(int'(dout_id));
        drive();
    endtask

    task automatic chk_log(input string tag, input int exp_ids[$]);
        chk({tag, "_len"}, 64'(out_log.size()), 64'(exp_ids.size()));
        for (int i = 0; i < exp_ids.size() && i < out_log.size(); i++) begin
            chk(tag, 64'(out_log[i]), 64'(exp_ids[i]));
        end
    endtask

    initial begin
        int exp_ids[$];
        total = 0; bad = 0;
        m_ptr = 0; m_owner = 0; m_locked = 1'b0;
        m_valid = 1'b0; m_data = '0; m_id = '0; m_eot = '0;
        req_valid = '0; req_a = '0; req_b = '0; req_eot = '0;
        dout_ready = 1'b1;
        rst = 1'b1;

        // Reset with every requester pending: ready must stay low.
        for (int i = 0; i < N; i++) push(i, 32'd1, 32'd1, 2'b01);
        drive();
        cycle();
        cycle();
        for (int i = 0; i < N; i++) bq[i].delete();
        drive();
        rst = 1'b0;
        cycle();

        // Single beat from requester 1.
        push(1, 32'd5, 32'd7, 2'b01);
        drive();
        #2;
        chk("single_ready", 64'(req_ready), 64'(4'b0010));
        cycle();
        chk("single_data", 64'(dout_data), 64'd12);
        chk("single_id", 64'(dout_id), 64'd1);
        chk("single_eot", 64'(dout_eot), 64'(2'b01));
        cycle();
        // ptr is now 2: requester 2 wins over requester 1.
        push(1, 32'd1, 32'd2, 2'b01);
        push(2, 32'd3, 32'd4, 2'b01);
        drive();
        out_log.delete();
        repeat (3) cycle();
        exp_ids = '{2, 1};
        chk_log("ptr_after_single", exp_ids);

        // Round-robin from a fresh reset, eight single-beat packets back to back.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int j = 0; j < 2; j++)
            for (int i = 0; i < N; i++) push(i, $urandom, $urandom, 2'b01);
        drive();
        out_log.delete();
        repeat (8) cycle();
        exp_ids = '{0, 1, 2, 3, 0, 1, 2, 3};
        chk_log("round_robin", exp_ids);
        repeat (2) cycle();

        // Packet lock: move ptr to 2, then requester 2 sends a 3-beat packet.
        push(1, 32'd9, 32'd9, 2'b01);
        drive();
        repeat (2) cycle();
        push(2, 32'd10, 32'd1, 2'b00);
        push(2, 32'd20, 32'd2, 2'b00);
        push(2, 32'd30, 32'd3, 2'b10);
        push(0, 32'd40, 32'd4, 2'b01);
        push(3, 32'd50, 32'd5, 2'b01);
        drive();
        out_log.delete();
        repeat (7) cycle();
        exp_ids = '{2, 2, 2, 3, 0};
        chk_log("packet_lock", exp_ids);

        // Backpressure: output held three cycles, then drain and accept together.
        for (int i = 0; i < 4; i++) push(0, $urandom, $urandom, 2'b01);
        drive();
        cycle();
        dout_ready = 1'b0;
        repeat (3) cycle();
        dout_ready = 1'b1;
        repeat (5) cycle();

        // Carry discarded, ptr wraps from 3 to 0.
        push(3, 32'hFFFF_FFFF, 32'h0000_0002, 2'b01);
        drive();
        cycle();
        chk("wrap_data", 64'(dout_data), 64'h1);
        chk("wrap_id", 64'(dout_id), 64'd3);
        push(1, 32'd1, 32'd1, 2'b01);
        push(0, 32'd2, 32'd2, 2'b01);
        drive();
        out_log.delete();
        repeat (3) cycle();
        exp_ids = '{0, 1};
        chk_log("ptr_wrap", exp_ids);

        // Reset mid-packet: requester 1 locked, reset, then 1 beats 2 from ptr 0.
        push(1, 32'd7, 32'd7, 2'b00);
        drive();
        cycle();
        rst = 1'b1;
        cycle();
        chk("rst_mid_valid", 64'(dout_valid), 64'd0);
        rst = 1'b0;
        push(2, 32'd1, 32'd0, 2'b01);
        push(1, 32'd2, 32'd0, 2'b01);
        drive();
        out_log.delete();
        repeat (3) cycle();
        exp_ids = '{1, 2};
        chk_log("rst_mid_order", exp_ids);

        // Random traffic with random backpressure.
        for (int c = 0; c < 600; c++) begin
            int r;
            if ($urandom_range(0, 2) != 0) begin
                r = $urandom_range(0, N - 1);
                if (bq[r].size() < 4) push(r, $urandom, $urandom, 2'($urandom_range(0, 3)));
            end
            dout_ready = ($urandom_range(0, 3) != 0);
            drive();
            cycle();
        end
        // Drain whatever is left; packets ending in eot=0 may leave a lock held.
        dout_ready = 1'b1;
        drive();
        repeat (40) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
